seq_alu: RTL

- Registered, parametrised-width ARM-style ALU with an internal NZCV flag register.
- Adds three things the combinational ALU lacks:
  - carry-in is taken from the held C flag;
  - flags are written only when the S bit is set;
  - a multi-cycle shift-add MUL.
- Sits between the register-file operand latches and the writeback/CPSR stage of the datapath.
- Uses a start/busy/done handshake.

---
 rtl/seq_alu_if.sv | 29 ++
 rtl/seq_alu.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/seq_alu_if.sv
// rtl/seq_alu_if.sv - operand/result handshake bundle between the operand latches and seq_alu
interface seq_alu_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [4:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             s_bit;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             wr_en;
   logic             bad_op;
   logic             n_flag;
   logic             z_flag;
   logic             c_flag;
   logic             v_flag;

   modport master (
      output start, op, a, b, s_bit,
      input  busy, done, result, wr_en, bad_op, n_flag, z_flag, c_flag, v_flag
   );

   modport slave (
      input  start, op, a, b, s_bit,
      output busy, done, result, wr_en, bad_op, n_flag, z_flag, c_flag, v_flag
   );
endinterface

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - registered ARM-style ALU with held NZCV flags and shift-add multiply
module seq_alu #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input logic      clk,
   input logic      reset,
   seq_alu_if.slave bus
);
   localparam logic [4:0] OP_AND = 5'h00, OP_BIC = 5'h01, OP_ORR = 5'h02, OP_EOR = 5'h03;
   localparam logic [4:0] OP_ADD = 5'h04, OP_ADC = 5'h05, OP_SUB = 5'h06, OP_SBC = 5'h07;
   localparam logic [4:0] OP_RSB = 5'h08, OP_RSC = 5'h09, OP_MOV = 5'h0A, OP_MVN = 5'h0B;
   localparam logic [4:0] OP_TST = 5'h0C, OP_TEQ = 5'h0D, OP_CMP = 5'h0E, OP_CMN = 5'h0F;
   localparam logic [4:0] OP_MUL = 5'h10;

   typedef enum logic {IDLE, MUL} state_t;

   state_t           state;
   logic             busyR, doneR, wrEnR, badOpR;
   logic             nReg, zReg, cReg, vReg;
   logic [WIDTH-1:0] resultR;
   logic [WIDTH-1:0] aSh, bSh, acc;
   logic [CNT_W-1:0] cnt;
   logic             mulS;

   logic [WIDTH-1:0] addX, addY, logicRes, aluRes, accNext;
   logic [WIDTH:0]   aluSum;
   logic             addCin, isArith, isDefined, isCompare, aluV;

   // Every arithmetic op is expressed as addX + addY + addCin so C and V fall out uniformly.
   always_comb begin
      addX      = bus.a;
      addY      = bus.b;
      addCin    = 1'b0;
      isArith   = 1'b0;
      isDefined = 1'b1;
      logicRes  = '0;
      case (bus.op)
         OP_AND, OP_TST: logicRes = bus.a & bus.b;
         OP_BIC:         logicRes = bus.a & ~bus.b;
         OP_ORR:         logicRes = bus.a | bus.b;
         OP_EOR, OP_TEQ: logicRes = bus.a ^ bus.b;
         OP_MOV:         logicRes = bus.b;
         OP_MVN:         logicRes = ~bus.b;
         OP_ADD, OP_CMN: isArith = 1'b1;
         OP_ADC: begin
            isArith = 1'b1;
            addCin  = cReg;
         end
         OP_SUB, OP_CMP: begin
            isArith = 1'b1;
            addY    = ~bus.b;
            addCin  = 1'b1;
         end
         OP_SBC: begin
            isArith = 1'b1;
            addY    = ~bus.b;
            addCin  = cReg;
         end
         OP_RSB: begin
            isArith = 1'b1;
            addX    = bus.b;
            addY    = ~bus.a;
            addCin  = 1'b1;
         end
         OP_RSC: begin
            isArith = 1'b1;
            addX    = bus.b;
            addY    = ~bus.a;
            addCin  = cReg;
         end
         default: isDefined = 1'b0;
      endcase
      aluSum    = {1'b0, addX} + {1'b0, addY} + {{WIDTH{1'b0}}, addCin};
      aluRes    = isArith ? aluSum[WIDTH-1:0] : logicRes;
      aluV      = (addX[WIDTH-1] == addY[WIDTH-1]) && (aluSum[WIDTH-1] != addX[WIDTH-1]);
      isCompare = (bus.op[4:2] == 3'b011);
      accNext   = acc + (bSh[0] ? aSh : '0);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         busyR   <= 1'b0;
         doneR   <= 1'b0;
         wrEnR   <= 1'b0;
         badOpR  <= 1'b0;
         resultR <= '0;
         nReg    <= 1'b0;
         zReg    <= 1'b0;
         cReg    <= 1'b0;
         vReg    <= 1'b0;
         aSh     <= '0;
         bSh     <= '0;
         acc     <= '0;
         cnt     <= '0;
         mulS    <= 1'b0;
      end else begin
         doneR <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  if (bus.op == OP_MUL) begin
                     aSh   <= bus.a;
                     bSh   <= bus.b;
                     mulS  <= bus.s_bit;
                     acc   <= '0;
                     cnt   <= '0;
                     busyR <= 1'b1;
                     state <= MUL;
                  end else begin
                     doneR   <= 1'b1;
                     resultR <= isDefined ? aluRes : '0;
                     wrEnR   <= isDefined && !isCompare;
                     badOpR  <= !isDefined;
                     // Compare ops always update flags, matching ARM TST/TEQ/CMP/CMN.
                     if (isDefined && (bus.s_bit || isCompare)) begin
                        nReg <= aluRes[WIDTH-1];
                        zReg <= (aluRes == '0);
                        if (isArith) begin
                           cReg <= aluSum[WIDTH];
                           vReg <= aluV;
                        end
                     end
                  end
               end
            end
            MUL: begin
               acc <= accNext;
               aSh <= aSh << 1;
               bSh <= bSh >> 1;
               cnt <= cnt + 1'b1;
               if (cnt == CNT_W'(WIDTH - 1)) begin
                  resultR <= accNext;
                  doneR   <= 1'b1;
                  wrEnR   <= 1'b1;
                  badOpR  <= 1'b0;
                  busyR   <= 1'b0;
                  state   <= IDLE;
                  if (mulS) begin
                     nReg <= accNext[WIDTH-1];
                     zReg <= (accNext == '0);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy   = busyR;
   assign bus.done   = doneR;
   assign bus.result = resultR;
   assign bus.wr_en  = wrEnR;
   assign bus.bad_op = badOpR;
   assign bus.n_flag = nReg;
   assign bus.z_flag = zReg;
   assign bus.c_flag = cReg;
   assign bus.v_flag = vReg;
endmodule
